// File: rtl/int_to_float_pkg.sv
// Shared types, constants and helpers for the pipelined integer-to-float converter.
//   bias(exp_w)   : exponent bias 2^(exp_w-1)-1
//   clog2(v)      : ceiling log2, used to size leading-zero counts
//   s2_payload_t  : stage-2 to stage-3 payload (normalised operand + control)
package int_to_float_pkg;

  localparam logic ROUND_TRUNC = 1'b0;
  localparam logic ROUND_RNE   = 1'b1;

  // Widest integer operand the stage-2 payload can carry; narrower operands are
  // left-aligned inside it so the low padding bits are zero.
  localparam int unsigned MAX_IN_W = 128;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(v)) r++;
    return r;
  endfunction

  function automatic int unsigned bias(input int unsigned exp_w);
    return (32'd1 << (exp_w - 32'd1)) - 32'd1;
  endfunction

  localparam int unsigned LZC_W = clog2(MAX_IN_W + 1);

  typedef struct packed {
    logic                sign;
    logic [MAX_IN_W-1:0] norm_mag;  // leading 1 at the MSB, zero-padded below
    logic [LZC_W-1:0]    lzc;
    logic                zero;
    logic                round;
  } s2_payload_t;

endpackage

// File: rtl/int_to_float_pipe_lzc.sv
// Combinational leading-zero counter.
//   value    : operand
//   count    : number of leading zeros (WIDTH when value is zero)
//   all_zero : value == 0
module leading_zero_counter
  import int_to_float_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0]             value,
  output logic [clog2(WIDTH+1)-1:0]    count,
  output logic                         all_zero
);

  localparam int unsigned CNT_W = clog2(WIDTH + 1);

  // Scan upward so the highest set bit wins.
  always_comb begin
    count = CNT_W'(WIDTH);
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (value[i]) count = CNT_W'(WIDTH - 32'd1 - i);
    end
  end

  assign all_zero = ~|value;

endmodule

// File: rtl/int_to_float_pipe.sv
// Three-stage pipelined integer to binary floating-point converter.
//   in_valid/in_ready   : input handshake; in_ready = !out_valid || out_ready
//   in_data             : integer operand, signed or unsigned per in_signed
//   in_round            : 0 truncate, 1 round to nearest even
//   out_valid/out_ready : output handshake, whole pipe stalls on backpressure
//   out_data            : {sign, biased exponent, fraction}
//   out_inexact         : result differs from the integer value
//   out_overflow        : magnitude too large; out_data is signed infinity
module int_to_float_pipe
  import int_to_float_pkg::*;
#(
  parameter int unsigned IN_W  = 32,
  parameter int unsigned EXP_W = 8,
  parameter int unsigned MAN_W = 23
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [IN_W-1:0]      in_data,
  input  logic                 in_signed,
  input  logic                 in_round,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [EXP_W+MAN_W:0] out_data,
  output logic                 out_inexact,
  output logic                 out_overflow
);

  localparam int unsigned BIAS       = bias(EXP_W);
  localparam int unsigned EMAX_FIELD = (32'd1 << EXP_W) - 32'd2;
  localparam int unsigned CNT_W      = clog2(IN_W + 1);
  localparam int unsigned EXT_W      = MAX_IN_W + MAN_W + 2;
  localparam int unsigned EV_W       = 32;

  logic adv;
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  // Stage 1: sign and magnitude; the unsigned negate maps the most negative
  // value to 2^(IN_W-1) without overflow.
  logic            in_neg;
  logic [IN_W-1:0] in_mag;
  logic            s1_valid, s1_sign, s1_round;
  logic [IN_W-1:0] s1_mag;

  always_comb begin
    in_neg = in_signed & in_data[IN_W-1];
    in_mag = in_neg ? (~in_data + IN_W'(1)) : in_data;
  end

  // Stage 2: normalise so the leading 1 lands on the payload MSB.
  logic [CNT_W-1:0] lzc_cnt;
  logic             lzc_zero;
  logic [IN_W-1:0]  norm;
  s2_payload_t      s2_d, s2_q;
  logic             s2_valid;

  leading_zero_counter #(.WIDTH(IN_W)) u_lzc (
    .value    (s1_mag),
    .count    (lzc_cnt),
    .all_zero (lzc_zero)
  );

  always_comb begin
    s2_d          = '0;
    norm          = s1_mag << lzc_cnt;
    s2_d.sign     = s1_sign;
    s2_d.norm_mag = MAX_IN_W'(norm) << (MAX_IN_W - IN_W);
    s2_d.lzc      = LZC_W'(lzc_cnt);
    s2_d.zero     = lzc_zero;
    s2_d.round    = s1_round;
  end

  // Stage 3: round and pack. The extension below the payload zero-pads the
  // fraction when the operand has fewer bits than the mantissa.
  logic [EXT_W-1:0]     ext;
  logic [MAN_W-1:0]     frac;
  logic                 guard, sticky, round_up, carry;
  logic [MAN_W+1:0]     sig_rnd;
  logic [EV_W-1:0]      exp_full;
  logic [EXP_W+MAN_W:0] res_data;
  logic                 res_inexact, res_overflow;

  always_comb begin
    ext      = {s2_q.norm_mag, (MAN_W+2)'(0)};
    frac     = ext[EXT_W-2 -: MAN_W];
    guard    = ext[EXT_W-2-MAN_W];
    sticky   = |ext[EXT_W-3-MAN_W:0];
    round_up = (s2_q.round == ROUND_RNE) && guard && (sticky || frac[0]);
    // Hidden bit included so a full-fraction increment carries out cleanly.
    sig_rnd  = {1'b0, ext[EXT_W-1], frac} + (MAN_W+2)'(round_up);
    carry    = sig_rnd[MAN_W+1];
    exp_full = EV_W'(IN_W - 1) - EV_W'(s2_q.lzc) + EV_W'(carry) + EV_W'(BIAS);

    res_data     = '0;
    res_inexact  = 1'b0;
    res_overflow = 1'b0;
    if (!s2_q.zero) begin
      if (exp_full > EV_W'(EMAX_FIELD)) begin
        res_data     = {s2_q.sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        res_inexact  = 1'b1;
        res_overflow = 1'b1;
      end else begin
        res_data    = {s2_q.sign, EXP_W'(exp_full), MAN_W'(sig_rnd)};
        res_inexact = guard | sticky;
      end
    end
  end

  // Valids and output register: reset clears everything in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid     <= 1'b0;
      s2_valid     <= 1'b0;
      out_valid    <= 1'b0;
      out_data     <= '0;
      out_inexact  <= 1'b0;
      out_overflow <= 1'b0;
    end else if (adv) begin
      s1_valid  <= in_valid;
      s2_valid  <= s1_valid;
      out_valid <= s2_valid;
      if (s2_valid) begin
        out_data     <= res_data;
        out_inexact  <= res_inexact;
        out_overflow <= res_overflow;
      end
    end
  end

  // Datapath registers only load on a valid beat; no reset needed.
  always_ff @(posedge clk) begin
    if (adv) begin
      if (in_valid) begin
        s1_sign  <= in_neg;
        s1_mag   <= in_mag;
        s1_round <= in_round;
      end
      if (s1_valid) s2_q <= s2_d;
    end
  end

endmodule

// File: tb/tb_int_to_float_pipe.sv
// Scoreboard bench for int_to_float_pipe: default binary32 instance (dut0)
// and a 5/10 half-precision instance (dut1) sharing the operand bus.
`timescale 1ns/1ps
module tb_int_to_float_pipe;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] in_data;
  logic        in_signed, in_round;

  logic        v0, r0, ov0, or0, inx0, ovf0;
  logic [31:0] od0;
  logic        v1, r1, ov1, or1, inx1, ovf1;
  logic [15:0] od1;

  int_to_float_pipe dut0 (
    .clk(clk), .reset(reset), .in_valid(v0), .in_ready(r0), .in_data(in_data),
    .in_signed(in_signed), .in_round(in_round), .out_valid(ov0), .out_ready(or0),
    .out_data(od0), .out_inexact(inx0), .out_overflow(ovf0)
  );

  int_to_float_pipe #(.IN_W(32), .EXP_W(5), .MAN_W(10)) dut1 (
    .clk(clk), .reset(reset), .in_valid(v1), .in_ready(r1), .in_data(in_data),
    .in_signed(in_signed), .in_round(in_round), .out_valid(ov1), .out_ready(or1),
    .out_data(od1), .out_inexact(inx1), .out_overflow(ovf1)
  );

  typedef struct {
    logic [31:0] data;
    logic        inx;
    logic        ovf;
    bit          lat;
    int          cyc;
  } exp_t;

  exp_t sb0[$];
  exp_t sb1[$];
  int   n_chk = 0;
  int   n_fail = 0;
  int   cyc = 0;

  logic [31:0] ints_f[16] = '{
    32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000,
    32'h40A00000, 32'h40C00000, 32'h40E00000, 32'h41000000,
    32'h41100000, 32'h41200000, 32'h41300000, 32'h41400000,
    32'h41500000, 32'h41600000, 32'h41700000, 32'h41800000
  };

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", name, act, req);
    end
  endtask

  // Drive one operand to the selected instance; expectation is queued on accept.
  task automatic send(input int which, input logic [31:0] d, input logic sgn, input logic rnd,
                      input logic [31:0] xd, input logic xi, input logic xo, input bit lat);
    exp_t e;
    bit   done;
    done = 1'b0;
    @(negedge clk);
    in_data   = d;
    in_signed = sgn;
    in_round  = rnd;
    if (which == 0) v0 = 1'b1; else v1 = 1'b1;
    for (int k = 0; k < 50 && !done; k++) begin
      if (k > 0) @(negedge clk);
      #4;
      if ((which == 0) ? r0 : r1) begin
        e = '{data: xd, inx: xi, ovf: xo, lat: lat, cyc: cyc};
        if (which == 0) sb0.push_back(e); else sb1.push_back(e);
        done = 1'b1;
      end
    end
    if (!done) check("send_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    v0 = 1'b0;
    v1 = 1'b0;
  endtask

  task automatic drain();
    int k;
    k = 0;
    while ((sb0.size() != 0 || sb1.size() != 0) && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (k >= 200) check("drain_timeout", 32'(sb0.size() + sb1.size()), 32'd0);
    repeat (2) @(negedge clk);
  endtask

  // Monitor for dut0: pops on every transfer, checks hold behaviour when stalled.
  logic [31:0] hold0;
  bit          stall0 = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    #3;
    if (reset) begin
      stall0 = 1'b0;
    end else begin
      if (stall0) begin
        check("hold_valid", 32'(ov0), 32'd1);
        check("hold_data", od0, hold0);
      end
      stall0 = 1'b0;
      if (ov0 && !or0) begin
        check("stall_in_ready", 32'(r0), 32'd0);
        hold0  = od0;
        stall0 = 1'b1;
      end
      if (ov0 && or0) begin
        if (sb0.size() == 0) begin
          check("unexpected_out0", 32'd1, 32'd0);
        end else begin
          e = sb0.pop_front();
          check("data0", od0, e.data);
          check("inexact0", 32'(inx0), 32'(e.inx));
          check("overflow0", 32'(ovf0), 32'(e.ovf));
          if (e.lat) check("latency0", 32'(cyc), 32'(e.cyc + 3));
        end
      end
    end
  end

  // Monitor for dut1 (never backpressured).
  always @(negedge clk) begin
    exp_t e;
    #3;
    if (!reset && ov1 && or1) begin
      if (sb1.size() == 0) begin
        check("unexpected_out1", 32'd1, 32'd0);
      end else begin
        e = sb1.pop_front();
        check("data1", 32'(od1), e.data);
        check("inexact1", 32'(inx1), 32'(e.inx));
        check("overflow1", 32'(ovf1), 32'(e.ovf));
        if (e.lat) check("latency1", 32'(cyc), 32'(e.cyc + 3));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; v0 = 1'b0; v1 = 1'b0; or0 = 1'b1; or1 = 1'b1;
    in_data = 32'd0; in_signed = 1'b0; in_round = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #3;
    check("rst_out_valid", 32'(ov0), 32'd0);
    check("rst_out_data", od0, 32'd0);
    check("rst_flags", 32'({inx0, ovf0}), 32'd0);
    check("rst_in_ready", 32'(r0), 32'd1);
    check("rst_out_valid1", 32'(ov1), 32'd0);

    // Binary32, signed and unsigned, both rounding modes.
    send(0, 32'h00000001, 1, 1, 32'h3F800000, 0, 0, 1);
    send(0, 32'hFFFFFFFF, 1, 1, 32'hBF800000, 0, 0, 1);
    send(0, 32'h00000000, 1, 1, 32'h00000000, 0, 0, 1);
    send(0, 32'h80000000, 1, 1, 32'hCF000000, 0, 0, 1);
    send(0, 32'h80000000, 0, 1, 32'h4F000000, 0, 0, 1);
    send(0, 32'h7FFFFFFF, 1, 1, 32'h4F000000, 1, 0, 1);
    send(0, 32'hFFFFFFFB, 1, 0, 32'hC0A00000, 0, 0, 1);
    send(0, 32'h01000001, 0, 1, 32'h4B800000, 1, 0, 1);
    send(0, 32'h01000003, 0, 1, 32'h4B800002, 1, 0, 1);
    send(0, 32'h01000005, 0, 1, 32'h4B800002, 1, 0, 1);
    send(0, 32'h01000003, 0, 0, 32'h4B800001, 1, 0, 1);
    send(0, 32'hFFFFFFFF, 0, 0, 32'h4F7FFFFF, 1, 0, 1);
    send(0, 32'hFFFFFFFF, 0, 1, 32'h4F800000, 1, 0, 1);
    drain();

    // Half-precision layout: overflow and the largest finite value.
    send(1, 32'd70000,     0, 1, 32'h7C00, 1, 1, 1);
    send(1, 32'd65520,     0, 1, 32'h7C00, 1, 1, 1);
    send(1, 32'd65520,     0, 0, 32'h7BFF, 1, 0, 1);
    send(1, 32'd65504,     0, 1, 32'h7BFF, 0, 0, 1);
    send(1, 32'd1,         0, 1, 32'h3C00, 0, 0, 1);
    send(1, 32'hFFFEEE90,  1, 1, 32'hFC00, 1, 1, 1);
    send(1, 32'd0,         1, 1, 32'h0000, 0, 0, 1);
    drain();

    // Back-to-back stream with exact latency on every result.
    for (int i = 0; i < 8; i++) send(0, 32'(i + 1), 0, 1, ints_f[i], 0, 0, 1);
    drain();

    // Stream under a 5-cycle output stall.
    fork
      for (int i = 8; i < 16; i++) send(0, 32'(i + 1), 0, 1, ints_f[i], 0, 0, 0);
      begin
        repeat (4) @(negedge clk);
        or0 = 1'b0;
        repeat (5) @(negedge clk);
        or0 = 1'b1;
      end
    join
    drain();

    // Asynchronous reset with three transactions in flight.
    send(0, 32'd100, 0, 1, 32'h42C80000, 0, 0, 0);
    send(0, 32'd100, 0, 1, 32'h42C80000, 0, 0, 0);
    send(0, 32'd100, 0, 1, 32'h42C80000, 0, 0, 0);
    #1;
    check("pre_reset_valid", 32'(ov0), 32'd1);
    reset = 1'b1;
    #1;
    check("async_reset_valid", 32'(ov0), 32'd0);
    check("async_reset_in_ready", 32'(r0), 32'd1);
    sb0.delete();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      #3;
      check("no_stale_out", 32'(ov0), 32'd0);
    end
    send(0, 32'd3, 0, 1, 32'h40400000, 0, 0, 1);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/int_to_float_pipe.md
Name: int_to_float_pipe

Overview:
- Pipelined, parametrised integer-to-floating-point converter; next generation of the combinational 32-bit signed-to-binary32 converter in multi_standard.
- Adds generic input/exponent/mantissa widths, a per-transaction signed/unsigned select, and round-to-nearest-even or truncate rounding.
- Adds inexact/overflow flags and a valid/ready stream interface with full-throughput backpressure.
- Sits between integer datapath producers and float consumers in the multi_standard datapath.

Parameters:
IN_W, 32, integer input width (>=2)
EXP_W, 8, exponent field width (>=3)
MAN_W, 23, stored mantissa (fraction) width (>=2)

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-high reset
in_valid  input  1  input transaction present
in_ready  output  1  block accepts input this cycle
in_data  input  IN_W  integer operand
in_signed  input  1  1: in_data is two's complement; 0: unsigned
in_round  input  1  0: truncate toward zero; 1: round to nearest, ties to even
out_valid  output  1  result present
out_ready  input  1  consumer accepts result
out_data  output  1+EXP_W+MAN_W  {sign, biased exponent, fraction}
out_inexact  output  1  result differs from exact integer value
out_overflow  output  1  magnitude exceeded the largest finite value; out_data is signed infinity

Behaviour:
- Clock is clk; reset is asynchronous, active-high. On reset assertion, immediately and independently of clk, all stage valids clear. Reset values: out_valid=0, out_data=0, out_inexact=0, out_overflow=0. in_ready=1 after reset.
- BIAS = 2^(EXP_W-1)-1. EMAX_FIELD = 2^EXP_W-2.
- Pipeline has 3 register stages. Global advance enable is adv = !out_valid || out_ready. in_ready = adv. A transfer occurs when in_valid && in_ready.
- Latency is 3 cycles from accepted input to out_valid, with out_ready held high. Throughput is one result per cycle.
- Stage 1:
  - sign = in_signed & in_data[IN_W-1].
  - mag = sign ? -in_data : in_data, computed as unsigned IN_W bits, so the most negative value yields 2^(IN_W-1) with no overflow.
  - Latch in_round.
- Stage 2:
  - Leading-zero count of mag, giving msb position p.
  - Left-normalise mag so the leading 1 sits at bit IN_W-1.
  - zero = (mag==0).
- Stage 3:
  - Fraction = the MAN_W bits below the leading 1. Guard = the next bit. Sticky = OR of all remaining bits. When IN_W-1 <= MAN_W, the fraction is zero-padded and guard = sticky = 0.
  - Round-to-nearest-even: increment if guard && (sticky || fraction LSB).
  - Truncate: never increment.
  - Increment carry-out sets fraction=0 and adds 1 to p.
  - inexact = guard | sticky, independent of rounding mode.
  - Exponent = p + BIAS. If exponent > EMAX_FIELD, the result is {sign, all-ones, zero}, with overflow=1 and inexact=1.
  - zero input gives out_data=0 (positive zero, also for signed inputs), with both flags 0.
- Output hold: while out_valid && !out_ready, out_data and the flags stay stable and no stage advances. in_valid gaps propagate as bubbles and do not stall upstream results.
- Reset during operation discards all in-flight transactions. The next accepted input after reset deassertion produces its result 3 cycles later.
- Each transaction uses its own in_signed and in_round. Changing them between cycles never affects in-flight data.

Decomposition:
- Package int_to_float_pkg holds:
  - functions bias(EXP_W) and clog2 for the LZC width;
  - localparams ROUND_TRUNC=1'b0 and ROUND_RNE=1'b1;
  - a packed struct for the stage-2 to stage-3 payload (sign, norm_mag, lzc, zero, round).
- One sub-module, leading_zero_counter, parametrised by WIDTH. It outputs count[clog2(WIDTH+1)-1:0] and all_zero, and is purely combinational.

Test Plan:
- Default params, RNE, signed:
  - 1 -> 0x3F800000
  - -1 (0xFFFFFFFF) -> 0xBF800000
  - 0 -> 0x00000000
  - 0x80000000 -> 0xCF000000, inexact=0
- Unsigned, rounding:
  - 0x01000001 RNE -> 0x4B800000, inexact=1
  - 0x01000003 RNE -> 0x4B800002
  - 0x01000003 truncate -> 0x4B800001
  - 0xFFFFFFFF truncate -> 0x4F7FFFFF
  - 0xFFFFFFFF RNE -> 0x4F800000 (carry into exponent)
- IN_W=32, EXP_W=5, MAN_W=10, unsigned:
  - 70000 -> 0x7C00, overflow=1
  - 65520 RNE -> 0x7C00, overflow=1
  - 65520 truncate -> 0x7BFF, overflow=0, inexact=1
- Streaming: 8 back-to-back inputs with out_ready=1 -> 8 results on consecutive cycles, first 3 cycles after the first accept, in order.
- Backpressure: out_ready=0 for 5 cycles while streaming -> in_ready=0 from the cycle out_valid rises; out_data stable; no loss or duplication after release.
- Reset mid-stream: assert reset asynchronously (between clk edges) with 3 in flight -> out_valid drops immediately, no stale results afterward; next input result appears 3 cycles after accept.
